// File: rtl/cardinal_nic_endpoint.sv
// cardinal_nic_endpoint: per-node NIC between a processing element and one
// local port of the cardinal_router mesh. TX encodes (dest, payload) into a
// 64-bit routing flit and injects it with a one-beat si pulse; RX buffers one
// ejected flit, decodes its header fields and flags nonzero hop fields.
module cardinal_nic_endpoint #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 64,
    parameter int NODE_X = 0,
    parameter int NODE_Y = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [7:0]        tx_dst_x_i,
    input  logic [7:0]        tx_dst_y_i,
    input  logic [31:0]       tx_payload_i,
    output logic              tx_err_o,
    output logic              rx_valid_o,
    input  logic              rx_pop_i,
    output logic [DATA_W-1:0] rx_flit_o,
    output logic [7:0]        rx_src_x_o,
    output logic [7:0]        rx_src_y_o,
    output logic [31:0]       rx_payload_o,
    output logic              rx_hdr_err_o,
    output logic              net_si_o,
    output logic [DATA_W-1:0] net_di_o,
    input  logic              net_ri_i,
    input  logic              net_polarity_i,
    input  logic              net_so_i,
    input  logic [DATA_W-1:0] net_do_i,
    output logic              net_ro_o,
    output logic [CNT_W-1:0]  tx_cnt_o,
    output logic [CNT_W-1:0]  rx_cnt_o
);

    localparam logic [7:0] NX      = 8'(NODE_X);
    localparam logic [7:0] NY      = 8'(NODE_Y);
    localparam logic [7:0] COLS_L  = 8'(COLS);
    localparam logic [7:0] ROWS_L  = 8'(ROWS);
    localparam logic [7:0] MAX_HOP = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_e;

    tx_state_e          state_q;
    logic [62:0]        pend_q;
    logic               net_si_q;
    logic [DATA_W-1:0]  net_di_q;
    logic               tx_err_q;
    logic [CNT_W-1:0]   tx_cnt_q;

    logic               rx_valid_q;
    logic [DATA_W-1:0]  rx_flit_q;
    logic               rx_hdr_err_q;
    logic [CNT_W-1:0]   rx_cnt_q;

    logic               dx_dir, dy_dir;
    logic [7:0]         dx_mag, dy_mag;
    logic               req_bad_d;
    logic [62:0]        req_flit_d;

    // One-hot countdown: 0 hops -> 0000, n hops (1..4) -> bit n-1.
    function automatic logic [3:0] hop_enc(input logic [7:0] n);
        logic [3:0] r;
        r = 4'b0000;
        case (n)
            8'd1:    r = 4'b0001;
            8'd2:    r = 4'b0010;
            8'd3:    r = 4'b0100;
            8'd4:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Decode the PE request into direction/hop fields and a reject flag.
    always_comb begin
        dx_dir     = (tx_dst_x_i < NX);
        dx_mag     = dx_dir ? (NX - tx_dst_x_i) : (tx_dst_x_i - NX);
        dy_dir     = (tx_dst_y_i > NY);
        dy_mag     = dy_dir ? (tx_dst_y_i - NY) : (NY - tx_dst_y_i);
        req_bad_d  = (tx_dst_x_i >= COLS_L) || (tx_dst_y_i >= ROWS_L) ||
                     (dx_mag > MAX_HOP) || (dy_mag > MAX_HOP) ||
                     ((tx_dst_x_i == NX) && (tx_dst_y_i == NY));
        req_flit_d = {dx_dir, dy_dir, 5'b00000, hop_enc(dx_mag), hop_enc(dy_mag),
                      NX, NY, tx_payload_i};
    end

    // TX FSM: latch a good request, wait for router ready, pulse si once.
    // VC bit is taken from the router phase at the injection edge, not at request time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            net_si_q <= 1'b0;
            net_di_q <= '0;
            tx_err_q <= 1'b0;
            tx_cnt_q <= '0;
        end else begin
            tx_err_q <= 1'b0;
            net_si_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid_i) begin
                        if (req_bad_d) begin
                            tx_err_q <= 1'b1;
                        end else begin
                            pend_q  <= req_flit_d;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (net_ri_i) begin
                        net_si_q <= 1'b1;
                        net_di_q <= {net_polarity_i, pend_q};
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // RX one-entry buffer; accept and pop are mutually exclusive since
    // accept needs an empty buffer and pop needs a full one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid_q   <= 1'b0;
            rx_flit_q    <= '0;
            rx_hdr_err_q <= 1'b0;
            rx_cnt_q     <= '0;
        end else begin
            if (net_so_i && !rx_valid_q) begin
                rx_flit_q  <= net_do_i;
                rx_valid_q <= 1'b1;
                rx_cnt_q   <= rx_cnt_q + CNT_W'(1);
                if (net_do_i[55:48] != 8'd0) begin
                    rx_hdr_err_q <= 1'b1;
                end
            end else if (rx_pop_i && rx_valid_q) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign tx_ready_o   = (state_q == ST_IDLE);
    assign tx_err_o     = tx_err_q;
    assign net_si_o     = net_si_q;
    assign net_di_o     = net_di_q;
    assign tx_cnt_o     = tx_cnt_q;
    assign rx_valid_o   = rx_valid_q;
    assign rx_flit_o    = rx_flit_q;
    assign rx_src_x_o   = rx_flit_q[47:40];
    assign rx_src_y_o   = rx_flit_q[39:32];
    assign rx_payload_o = rx_flit_q[31:0];
    assign rx_hdr_err_o = rx_hdr_err_q;
    assign net_ro_o     = ~rx_valid_q;
    assign rx_cnt_o     = rx_cnt_q;

endmodule

// File: tb/tb_cardinal_nic_endpoint.sv
// Bench for cardinal_nic_endpoint: node A at (3,0) carries most scenarios,
// node B at (0,2) covers the zero-direction encoding case.
module tb_cardinal_nic_endpoint;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_tx_valid, a_tx_ready, a_tx_err, a_rx_valid, a_rx_pop, a_rx_hdr_err;
    logic        a_net_si, a_net_ri, a_net_pol, a_net_so, a_net_ro;
    logic [7:0]  a_dx, a_dy, a_rx_src_x, a_rx_src_y;
    logic [31:0] a_pay, a_rx_payload;
    logic [63:0] a_rx_flit, a_net_di, a_net_do;
    logic [15:0] a_tx_cnt, a_rx_cnt;

    logic        b_tx_valid, b_tx_ready, b_tx_err, b_rx_valid, b_rx_pop, b_rx_hdr_err;
    logic        b_net_si, b_net_ri, b_net_pol, b_net_so, b_net_ro;
    logic [7:0]  b_dx, b_dy, b_rx_src_x, b_rx_src_y;
    logic [31:0] b_pay, b_rx_payload;
    logic [63:0] b_rx_flit, b_net_di, b_net_do;
    logic [15:0] b_tx_cnt, b_rx_cnt;

    cardinal_nic_endpoint #(.ROWS(4), .COLS(4), .DATA_W(64), .NODE_X(3), .NODE_Y(0), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset),
        .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready), .tx_dst_x_i(a_dx), .tx_dst_y_i(a_dy),
        .tx_payload_i(a_pay), .tx_err_o(a_tx_err), .rx_valid_o(a_rx_valid), .rx_pop_i(a_rx_pop),
        .rx_flit_o(a_rx_flit), .rx_src_x_o(a_rx_src_x), .rx_src_y_o(a_rx_src_y),
        .rx_payload_o(a_rx_payload), .rx_hdr_err_o(a_rx_hdr_err), .net_si_o(a_net_si),
        .net_di_o(a_net_di), .net_ri_i(a_net_ri), .net_polarity_i(a_net_pol), .net_so_i(a_net_so),
        .net_do_i(a_net_do), .net_ro_o(a_net_ro), .tx_cnt_o(a_tx_cnt), .rx_cnt_o(a_rx_cnt)
    );

    cardinal_nic_endpoint #(.ROWS(4), .COLS(4), .DATA_W(64), .NODE_X(0), .NODE_Y(2), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset),
        .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready), .tx_dst_x_i(b_dx), .tx_dst_y_i(b_dy),
        .tx_payload_i(b_pay), .tx_err_o(b_tx_err), .rx_valid_o(b_rx_valid), .rx_pop_i(b_rx_pop),
        .rx_flit_o(b_rx_flit), .rx_src_x_o(b_rx_src_x), .rx_src_y_o(b_rx_src_y),
        .rx_payload_o(b_rx_payload), .rx_hdr_err_o(b_rx_hdr_err), .net_si_o(b_net_si),
        .net_di_o(b_net_di), .net_ri_i(b_net_ri), .net_polarity_i(b_net_pol), .net_so_i(b_net_so),
        .net_do_i(b_net_do), .net_ro_o(b_net_ro), .tx_cnt_o(b_tx_cnt), .rx_cnt_o(b_rx_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] txq[$];
    logic [63:0] rxq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference flit encoder written from the field layout using plain integers.
    function automatic logic [63:0] model_flit(input int nx, input int ny, input int dx, input int dy,
                                               input logic [31:0] pay, input logic pol);
        int hx, hy;
        logic [3:0] ex, ey;
        logic [63:0] f;
        hx = (dx > nx) ? dx - nx : nx - dx;
        hy = (dy > ny) ? dy - ny : ny - dy;
        ex = (hx == 0) ? 4'd0 : 4'(1 << (hx - 1));
        ey = (hy == 0) ? 4'd0 : 4'(1 << (hy - 1));
        f = 64'd0;
        f[63] = pol;
        f[62] = (dx < nx);
        f[61] = (dy > ny);
        f[55:52] = ex;
        f[51:48] = ey;
        f[47:40] = 8'(nx);
        f[39:32] = 8'(ny);
        f[31:0]  = pay;
        return f;
    endfunction

    task automatic pop_tx(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        chk({tag, "_qdepth"}, 64'(txq.size()), 64'd1);
        if (txq.size() != 0) begin
            e = txq.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic pop_rx(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        chk({tag, "_qdepth"}, 64'(rxq.size()), 64'd1);
        if (rxq.size() != 0) begin
            e = rxq.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic wait_si_a(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (a_net_si) seen = 1'b1;
        end
    endtask

    task automatic wait_si_b(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (b_net_si) seen = 1'b1;
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_tx_ready"}, 64'(a_tx_ready), 64'd1);
        chk({tag, "_net_si"}, 64'(a_net_si), 64'd0);
        chk({tag, "_net_di"}, a_net_di, 64'd0);
        chk({tag, "_tx_err"}, 64'(a_tx_err), 64'd0);
        chk({tag, "_rx_valid"}, 64'(a_rx_valid), 64'd0);
        chk({tag, "_net_ro"}, 64'(a_net_ro), 64'd1);
        chk({tag, "_rx_flit"}, a_rx_flit, 64'd0);
        chk({tag, "_hdr_err"}, 64'(a_rx_hdr_err), 64'd0);
        chk({tag, "_tx_cnt"}, 64'(a_tx_cnt), 64'd0);
        chk({tag, "_rx_cnt"}, 64'(a_rx_cnt), 64'd0);
    endtask

    initial begin
        bit seen;
        int si_cnt;
        logic [63:0] flit;

        reset = 1'b0;
        a_tx_valid = 0; a_rx_pop = 0; a_net_ri = 1; a_net_pol = 0; a_net_so = 0;
        a_dx = 0; a_dy = 0; a_pay = 0; a_net_do = 0;
        b_tx_valid = 0; b_rx_pop = 0; b_net_ri = 1; b_net_pol = 0; b_net_so = 0;
        b_dx = 0; b_dy = 0; b_pay = 0; b_net_do = 0;

        repeat (2) @(negedge clk);
        chk_reset_a("rst");
        reset = 1'b1;
        @(negedge clk);

        // Node A (3,0) -> (1,2), polarity 1.
        a_net_pol = 1; a_net_ri = 1;
        a_dx = 8'd1; a_dy = 8'd2; a_pay = 32'hDEADBEEF; a_tx_valid = 1;
        txq.push_back(model_flit(3, 0, 1, 2, 32'hDEADBEEF, 1'b1));
        @(negedge clk);
        a_tx_valid = 0;
        chk("t1_ready_low", 64'(a_tx_ready), 64'd0);
        wait_si_a(8, seen);
        chk("t1_si_seen", 64'(seen), 64'd1);
        pop_tx("t1_di", a_net_di);
        chk("t1_di_const", a_net_di, 64'hE022_0300_DEAD_BEEF);
        @(negedge clk);
        chk("t1_si_one_beat", 64'(a_net_si), 64'd0);
        chk("t1_tx_cnt", 64'(a_tx_cnt), 64'd1);
        chk("t1_ready_back", 64'(a_tx_ready), 64'd1);

        // Node B (0,2) -> (0,1), polarity 0.
        b_dx = 8'd0; b_dy = 8'd1; b_pay = 32'h12345678; b_tx_valid = 1;
        txq.push_back(model_flit(0, 2, 0, 1, 32'h12345678, 1'b0));
        @(negedge clk);
        b_tx_valid = 0;
        wait_si_b(8, seen);
        chk("t2_si_seen", 64'(seen), 64'd1);
        pop_tx("t2_di", b_net_di);
        chk("t2_di_const", b_net_di, 64'h0001_0002_1234_5678);
        @(negedge clk);
        chk("t2_tx_cnt", 64'(b_tx_cnt), 64'd1);

        // Router not ready for 10 cycles, then ready.
        a_net_ri = 0; a_net_pol = 0;
        a_dx = 8'd2; a_dy = 8'd3; a_pay = 32'h0BADF00D; a_tx_valid = 1;
        txq.push_back(model_flit(3, 0, 2, 3, 32'h0BADF00D, 1'b0));
        @(negedge clk);
        a_tx_valid = 0;
        si_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_net_si) si_cnt++;
            if (a_tx_ready) seen = 1'b1;
        end
        chk("t3_si_held_off", 64'(si_cnt), 64'd0);
        chk("t3_ready_stuck_low", 64'(seen), 64'd0);
        a_net_ri = 1;
        @(negedge clk);
        chk("t3_si_after_ri", 64'(a_net_si), 64'd1);
        pop_tx("t3_di", a_net_di);
        chk("t3_di_const", a_net_di, 64'h6014_0300_0BAD_F00D);
        flit = a_net_di;
        repeat (2) @(negedge clk);
        chk("t3_di_held", a_net_di, flit);
        chk("t3_tx_cnt", 64'(a_tx_cnt), 64'd2);

        // Rejected requests: self, dst_x out of range, dst_y out of range.
        for (int k = 0; k < 3; k++) begin
            a_dx = (k == 1) ? 8'd4 : 8'd3;
            a_dy = (k == 2) ? 8'd4 : 8'd0;
            a_pay = 32'h5555_0000 + 32'(k);
            a_tx_valid = 1;
            @(negedge clk);
            a_tx_valid = 0;
            chk($sformatf("t4_err_pulse_%0d", k), 64'(a_tx_err), 64'd1);
            chk($sformatf("t4_ready_%0d", k), 64'(a_tx_ready), 64'd1);
            chk($sformatf("t4_no_si_%0d", k), 64'(a_net_si), 64'd0);
            @(negedge clk);
            chk($sformatf("t4_err_clear_%0d", k), 64'(a_tx_err), 64'd0);
            chk($sformatf("t4_no_si2_%0d", k), 64'(a_net_si), 64'd0);
        end
        chk("t4_tx_cnt", 64'(a_tx_cnt), 64'd2);

        // RX: clean flit, second so ignored, pop, empty pop.
        a_net_do = 64'h0000_0102_CAFE_F00D; a_net_so = 1;
        rxq.push_back(64'h0000_0102_CAFE_F00D);
        @(negedge clk);
        a_net_do = 64'h0000_0203_1111_2222;
        chk("t5_rx_valid", 64'(a_rx_valid), 64'd1);
        chk("t5_net_ro", 64'(a_net_ro), 64'd0);
        pop_rx("t5_rx_flit", a_rx_flit);
        chk("t5_payload", 64'(a_rx_payload), 64'hCAFE_F00D);
        chk("t5_src_x", 64'(a_rx_src_x), 64'h01);
        chk("t5_src_y", 64'(a_rx_src_y), 64'h02);
        chk("t5_hdr_ok", 64'(a_rx_hdr_err), 64'd0);
        repeat (2) @(negedge clk);
        chk("t5_ignored_flit", a_rx_flit, 64'h0000_0102_CAFE_F00D);
        chk("t5_rx_cnt", 64'(a_rx_cnt), 64'd1);
        a_net_so = 0; a_rx_pop = 1;
        @(negedge clk);
        a_rx_pop = 0;
        chk("t5_popped", 64'(a_rx_valid), 64'd0);
        chk("t5_ro_back", 64'(a_net_ro), 64'd1);
        a_rx_pop = 1;
        @(negedge clk);
        a_rx_pop = 0;
        chk("t5_empty_pop_valid", 64'(a_rx_valid), 64'd0);
        chk("t5_empty_pop_cnt", 64'(a_rx_cnt), 64'd1);

        // RX header error is sticky.
        a_net_do = 64'h0001_0102_0000_0001; a_net_so = 1;
        rxq.push_back(64'h0001_0102_0000_0001);
        @(negedge clk);
        a_net_so = 0;
        pop_rx("t6_rx_flit", a_rx_flit);
        chk("t6_hdr_err", 64'(a_rx_hdr_err), 64'd1);
        a_rx_pop = 1;
        @(negedge clk);
        a_rx_pop = 0;
        a_net_do = 64'h0000_0001_ABCD_0123; a_net_so = 1;
        rxq.push_back(64'h0000_0001_ABCD_0123);
        @(negedge clk);
        a_net_so = 0;
        pop_rx("t6_rx_flit2", a_rx_flit);
        chk("t6_hdr_sticky", 64'(a_rx_hdr_err), 64'd1);
        chk("t6_rx_cnt", 64'(a_rx_cnt), 64'd3);

        // Reset asserted while a request waits in HOLD.
        a_net_ri = 0;
        a_dx = 8'd2; a_dy = 8'd1; a_pay = 32'h7777_8888; a_tx_valid = 1;
        @(negedge clk);
        a_tx_valid = 0;
        chk("t7_in_hold", 64'(a_tx_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk_reset_a("t7_rst");
        a_net_ri = 1;
        @(negedge clk);
        reset = 1'b1;
        si_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_net_si) si_cnt++;
        end
        chk("t7_no_si", 64'(si_cnt), 64'd0);
        chk("t7_ready", 64'(a_tx_ready), 64'd1);
        chk("t7_tx_cnt", 64'(a_tx_cnt), 64'd0);

        chk("end_txq_empty", 64'(txq.size()), 64'd0);
        chk("end_rxq_empty", 64'(rxq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
